// File: rtl/aib_tx_predriver.sv
// aib_tx_predriver: crowbar-free pad pre-driver FSM with strength and weak-pull control (AIB_TX_DEADTIME_EN adds the dead time)
module aib_tx_predriver #(
    parameter int DEAD_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TX_OE,
    input  logic       TX_DATA,
    input  logic       STR_REQ,
    input  logic [2:0] STR_CODE,
    output logic       STR_ACK,
    input  logic       WPU_EN,
    input  logic       WPD_EN,
    output logic       PDRV,
    output logic       NDRV,
    output logic [2:0] C_PDRV,
    output logic [2:0] C_NDRV,
    output logic       C_PU,
    output logic       C_PD,
    output logic       BUSY
);
    typedef enum logic [1:0] {OFF, HI, LO, DEAD} state_t;
    state_t state, nxt;
    logic [3:0] cnt, cnt_nxt;
    logic str_ok, str_held, fire;
    always_comb begin
        nxt = state;
        cnt_nxt = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
        if (!TX_OE) begin
            nxt = OFF;
            cnt_nxt = 4'd0;
        end else begin
            case (state)
                OFF: nxt = TX_DATA ? HI : LO;
                HI, LO: if (TX_DATA != (state == HI)) begin
                    cnt_nxt = 4'(DEAD_CYCLES - 1);
`ifdef AIB_TX_DEADTIME_EN
                    nxt = DEAD;
`else
                    nxt = TX_DATA ? HI : LO;
`endif
                end
`ifdef AIB_TX_DEADTIME_EN
                DEAD: if (cnt == 4'd0) nxt = TX_DATA ? HI : LO;
`endif
                default: nxt = OFF;
            endcase
        end
    end
`ifdef AIB_TX_DEADTIME_EN
    assign str_ok = (state == OFF) || (state == DEAD);
`else
    assign str_ok = (state == OFF);
`endif
    // one ack per request level: the requester must drop STR_REQ before another is taken
    assign fire = STR_REQ && str_ok && !str_held;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= OFF;
            cnt      <= 4'd0;
            PDRV     <= 1'b1;
            NDRV     <= 1'b0;
            BUSY     <= 1'b0;
            STR_ACK  <= 1'b0;
            str_held <= 1'b0;
            C_PDRV   <= 3'b111;
            C_NDRV   <= 3'b111;
            C_PU     <= 1'b1;
            C_PD     <= 1'b0;
        end else begin
            state    <= nxt;
            cnt      <= cnt_nxt;
            PDRV     <= (nxt != HI);
            NDRV     <= (nxt == LO);
            BUSY     <= (nxt != OFF);
            STR_ACK  <= fire;
            str_held <= STR_REQ && (str_held || fire);
            C_PDRV   <= fire ? STR_CODE : C_PDRV;
            C_NDRV   <= fire ? STR_CODE : C_NDRV;
            C_PU     <= ~(WPU_EN & ~WPD_EN);
            C_PD     <= WPD_EN & ~WPU_EN;
        end
    end
endmodule

// File: tb/tb_aib_tx_predriver.sv
// tb_aib_tx_predriver: scoreboard bench for aib_tx_predriver, expectations follow AIB_TX_DEADTIME_EN
module tb_aib_tx_predriver;
`ifdef AIB_TX_DEADTIME_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif
    logic CLK = 1'b0, RST, TX_OE, TX_DATA, STR_REQ, WPU_EN, WPD_EN;
    logic [2:0] STR_CODE;
    logic STR_ACK, PDRV, NDRV, C_PU, C_PD, BUSY;
    logic [2:0] C_PDRV, C_NDRV;
    logic STR_ACK4, PDRV4, NDRV4, C_PU4, C_PD4, BUSY4;
    logic [2:0] C_PDRV4, C_NDRV4;
    int n_chk = 0, n_pass = 0, crowbar = 0;

    typedef struct {
        string tag;
        int sel;
        logic [3:0] v;
    } exp_t;
    exp_t q[$];

    aib_tx_predriver #(.DEAD_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST), .TX_OE(TX_OE), .TX_DATA(TX_DATA), .STR_REQ(STR_REQ),
        .STR_CODE(STR_CODE), .STR_ACK(STR_ACK), .WPU_EN(WPU_EN), .WPD_EN(WPD_EN),
        .PDRV(PDRV), .NDRV(NDRV), .C_PDRV(C_PDRV), .C_NDRV(C_NDRV),
        .C_PU(C_PU), .C_PD(C_PD), .BUSY(BUSY)
    );
    aib_tx_predriver #(.DEAD_CYCLES(4)) dut4 (
        .CLK(CLK), .RST(RST), .TX_OE(TX_OE), .TX_DATA(TX_DATA), .STR_REQ(STR_REQ),
        .STR_CODE(STR_CODE), .STR_ACK(STR_ACK4), .WPU_EN(WPU_EN), .WPD_EN(WPD_EN),
        .PDRV(PDRV4), .NDRV(NDRV4), .C_PDRV(C_PDRV4), .C_NDRV(C_NDRV4),
        .C_PU(C_PU4), .C_PD(C_PD4), .BUSY(BUSY4)
    );

    always #5 CLK = ~CLK;

    assert property (@(posedge CLK) !(!PDRV && NDRV));
    assert property (@(posedge CLK) !(!PDRV4 && NDRV4));

    function automatic logic [3:0] obs(int sel);
        case (sel)
            0: return {2'b00, PDRV, NDRV};
            1: return {3'b000, BUSY};
            2: return {3'b000, STR_ACK};
            3: return {1'b0, C_PDRV};
            4: return {1'b0, C_NDRV};
            5: return {2'b00, C_PU, C_PD};
            6: return {2'b00, PDRV4, NDRV4};
            default: return {3'b000, BUSY4};
        endcase
    endfunction

    task automatic check(string tag, logic [3:0] got, logic [3:0] want);
        n_chk++;
        if (got !== want) $display("FAIL %s: got %0h want %0h", tag, got, want);
        else n_pass++;
    endtask

    task automatic expect_out(string tag, int sel, logic [3:0] v);
        q.push_back('{tag, sel, v});
    endtask

    task automatic step();
        exp_t e;
        @(posedge CLK);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            check(e.tag, obs(e.sel), e.v);
        end
    endtask

    initial begin
        RST = 1; TX_OE = 0; TX_DATA = 0; STR_REQ = 0; STR_CODE = 3'b000; WPU_EN = 0; WPD_EN = 0;
        step();
        expect_out("rst_legs", 0, 4'b10);
        expect_out("rst_busy", 1, 4'd0);
        expect_out("rst_ack", 2, 4'd0);
        expect_out("rst_cp", 3, 4'd7);
        expect_out("rst_cn", 4, 4'd7);
        expect_out("rst_pulls", 5, 4'b10);
        step();
        RST = 0;
        // dead time
        TX_OE = 1; TX_DATA = 1;
        expect_out("hi_legs", 0, 4'b00);
        expect_out("hi_busy", 1, 4'd1);
        step();
        TX_DATA = 0;
        if (DT) begin
            expect_out("dead1_legs", 0, 4'b10);
            expect_out("dead1_busy", 1, 4'd1);
            step();
            expect_out("dead2_legs", 0, 4'b10);
            step();
        end
        expect_out("lo_legs", 0, 4'b11);
        step();
        // abort, checked on the DEAD_CYCLES=4 instance
        TX_DATA = 1;
        expect_out("abort_pre", 6, DT ? 4'b10 : 4'b00);
        step();
        TX_OE = 0;
        expect_out("abort_off", 6, 4'b10);
        expect_out("abort_busy", 7, 4'd0);
        step();
        expect_out("abort_stay", 6, 4'b10);
        expect_out("abort_main", 0, 4'b10);
        step();
        // strength update held off while driving
        TX_OE = 1; TX_DATA = 1;
        expect_out("str_hi", 0, 4'b00);
        step();
        STR_REQ = 1; STR_CODE = 3'b010;
        expect_out("str_noack", 2, 4'd0);
        expect_out("str_cp_hold", 3, 4'd7);
        step();
        expect_out("str_noack2", 2, 4'd0);
        step();
        TX_OE = 0;
        expect_out("str_off", 0, 4'b10);
        expect_out("str_noack3", 2, 4'd0);
        step();
        expect_out("str_ack", 2, 4'd1);
        expect_out("str_cp", 3, 4'd2);
        expect_out("str_cn", 4, 4'd2);
        step();
        expect_out("str_ack_once", 2, 4'd0);
        step();
        STR_REQ = 0;
        expect_out("str_ack_low", 2, 4'd0);
        step();
        // weak pulls
        WPU_EN = 1; WPD_EN = 1;
        expect_out("wp_both", 5, 4'b10);
        step();
        WPD_EN = 0;
        expect_out("wp_pu", 5, 4'b00);
        step();
        WPU_EN = 0; WPD_EN = 1;
        expect_out("wp_pd", 5, 4'b11);
        step();
        // reset mid-drive
        TX_OE = 1; TX_DATA = 0;
        expect_out("mid_lo", 0, 4'b11);
        step();
        RST = 1;
        expect_out("mid_rst_legs", 0, 4'b10);
        expect_out("mid_rst_cp", 3, 4'd7);
        expect_out("mid_rst_busy", 1, 4'd0);
        expect_out("mid_rst_pulls", 5, 4'b10);
        step();
        RST = 0;
        // random traffic; crowbar must never appear
        for (int i = 0; i < 10000; i++) begin
            TX_OE = ($urandom_range(0, 7) != 0);
            TX_DATA = 1'($urandom);
            STR_REQ = 1'($urandom);
            STR_CODE = 3'($urandom);
            WPU_EN = 1'($urandom);
            WPD_EN = 1'($urandom);
            step();
            if ((!PDRV && NDRV) || (!PDRV4 && NDRV4)) crowbar++;
        end
        check("crowbar", 4'(crowbar), 4'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
